// File: rtl/code_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : code_pkg
//  Brief    : Shared state encoding and helpers for the code sender/detector.
//  Revision : 1.0  initial release
// ============================================================================
package code_pkg;

    // FSM state encoding, also exposed on the sender's state output
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } code_state_e;

    localparam int unsigned STATE_W = 2;

    // Width of a counter that must reach n-1; never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/code_shifter.sv
`default_nettype none
// ============================================================================
//  Module   : code_shifter
//  Brief    : MSB-first shift register with a saturating bit counter. On load
//             the word's MSB is handed out by the caller, so the register keeps
//             the remaining bits and bit_o always presents the next bit to send.
//  Revision : 1.0  initial release
// ============================================================================
module code_shifter
    import code_pkg::*;
#(
    parameter int CODE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [CODE_W-1:0] data_i,
    output logic              bit_o,
    output logic              last_o
);

    localparam int unsigned CNT_W = cnt_width(CODE_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CODE_W - 1);

    logic [CODE_W-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Next-state: load drops the MSB (already on the line), shift stops at the last bit
    always_comb begin
        sh_d  = sh_q;
        cnt_d = cnt_q;
        if (load_i) begin
            sh_d  = {data_i[CODE_W-2:0], 1'b0};
            cnt_d = '0;
        end else if (shift_i && (cnt_q != LAST_CNT)) begin
            sh_d  = {sh_q[CODE_W-2:0], 1'b0};
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Register stage with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    assign bit_o  = sh_q[CODE_W-1];
    assign last_o = (cnt_q == LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/code_sender.sv
`default_nettype none
// ============================================================================
//  Module   : code_sender
//  Brief    : Serialises a latched code word MSB first, repeated max(rep,1)
//             times with idle-high gaps, abortable, with registered outputs.
//  Revision : 1.0  initial release
// ============================================================================
module code_sender
    import code_pkg::*;
#(
    parameter int CODE_W   = 4,
    parameter int GAP_BITS = 2,
    parameter int REP_W    = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CODE_W-1:0]  code_in,
    input  logic [REP_W-1:0]   rep_in,
    input  logic               abort,
    output logic               x,
    output logic               x_valid,
    output logic               ready,
    output logic               done,
    output logic [STATE_W-1:0] state
);

    localparam bit                HAS_GAP  = (GAP_BITS > 0);
    localparam int unsigned       GAP_CW   = cnt_width(GAP_BITS);
    localparam logic [GAP_CW-1:0] GAP_LAST = GAP_CW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
    localparam logic [REP_W-1:0]  REP_ONE  = REP_W'(1);

    code_state_e        state_q;
    logic               x_q, xv_q, rdy_q, done_q;
    logic [CODE_W-1:0]  code_q;
    logic [REP_W-1:0]   rep_q;
    logic [GAP_CW-1:0]  gap_q;

    logic               w_accept, w_last_frame, w_frame_end;
    logic               w_load, w_shift, w_sh_bit, w_sh_last;
    logic [CODE_W-1:0]  w_load_data;

    // Control decode shared by the FSM and the shifter
    always_comb begin
        w_accept     = (state_q == ST_IDLE) && start && !abort;
        w_last_frame = (rep_q == REP_ONE);
        w_frame_end  = ((state_q == ST_SEND) && w_sh_last && !HAS_GAP) ||
                       ((state_q == ST_GAP) && (gap_q == GAP_LAST));
        w_load       = w_accept || (!abort && w_frame_end && !w_last_frame);
        w_load_data  = w_accept ? code_in : code_q;
        w_shift      = (state_q == ST_SEND) && !abort && !w_sh_last;
    end

    code_shifter #(
        .CODE_W (CODE_W)
    ) u_shifter (
        .clk     (clk),
        .rst     (rst),
        .load_i  (w_load),
        .shift_i (w_shift),
        .data_i  (w_load_data),
        .bit_o   (w_sh_bit),
        .last_o  (w_sh_last)
    );

    // Transfer FSM; every output is a flop updated alongside the state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            x_q     <= 1'b1;
            xv_q    <= 1'b0;
            rdy_q   <= 1'b1;
            done_q  <= 1'b0;
            code_q  <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        state_q <= ST_SEND;
                        x_q     <= code_in[CODE_W-1];
                        xv_q    <= 1'b1;
                        rdy_q   <= 1'b0;
                        code_q  <= code_in;
                        rep_q   <= (rep_in == '0) ? REP_ONE : rep_in;
                    end
                end
                ST_SEND: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        x_q     <= 1'b1;
                        xv_q    <= 1'b0;
                        rdy_q   <= 1'b1;
                    end else if (!w_sh_last) begin
                        x_q <= w_sh_bit;
                    end else if (HAS_GAP) begin
                        state_q <= ST_GAP;
                        x_q     <= 1'b1;
                        xv_q    <= 1'b0;
                        gap_q   <= '0;
                    end else if (w_last_frame) begin
                        state_q <= ST_IDLE;
                        x_q     <= 1'b1;
                        xv_q    <= 1'b0;
                        rdy_q   <= 1'b1;
                        done_q  <= 1'b1;
                    end else begin
                        rep_q <= rep_q - REP_ONE;
                        x_q   <= code_q[CODE_W-1];
                    end
                end
                ST_GAP: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        rdy_q   <= 1'b1;
                    end else if (gap_q == GAP_LAST) begin
                        if (w_last_frame) begin
                            state_q <= ST_IDLE;
                            rdy_q   <= 1'b1;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_SEND;
                            rep_q   <= rep_q - REP_ONE;
                            x_q     <= code_q[CODE_W-1];
                            xv_q    <= 1'b1;
                        end
                    end else begin
                        gap_q <= gap_q + GAP_CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    x_q     <= 1'b1;
                    xv_q    <= 1'b0;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end

    assign x       = x_q;
    assign x_valid = xv_q;
    assign ready   = rdy_q;
    assign done    = done_q;
    assign state   = state_q;

endmodule
`default_nettype wire

// File: doc/code_sender.md
CODE_SENDER -- requirements
Module: code_sender

Interface
REQ-001 SHALL have parameter CODE_W, default 4, meaning code word width in bits (>=2).
REQ-002 SHALL have parameter GAP_BITS, default 2, meaning idle-high bits between frames (>=0).
REQ-003 SHALL have parameter REP_W, default 3, meaning repeat-count field width.
REQ-004 SHALL have port clk  in  1  rising-edge clock, the only clock.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  in  1  request; accepted only when start=1 and ready=1 at a clk edge.
REQ-007 SHALL have port code_in  in  CODE_W  code word, sampled at acceptance.
REQ-008 SHALL have port rep_in  in  REP_W  frame repeat count, sampled at acceptance.
REQ-009 SHALL have port abort  in  1  synchronous cancel of the transfer in progress.
REQ-010 SHALL have port x  out  1  serial line, MSB first, idle level 1.
REQ-011 SHALL have port x_valid  out  1  high only while x carries a code bit.
REQ-012 SHALL have port ready  out  1  high in IDLE only.
REQ-013 SHALL have port done  out  1  one-cycle pulse on normal completion.
REQ-014 SHALL have port state  out  2  current FSM state encoding.

Function
REQ-015 SHALL implement FSM states IDLE=0, SEND=1, GAP=2; all outputs SHALL be registered.
REQ-016 In IDLE, x=1, x_valid=0, ready=1; acceptance SHALL latch code_in into a shift register and rep_in into a repeat counter, then move to SEND.
REQ-017 rep_in=0 SHALL be treated as 1; the transfer SHALL emit max(rep_in,1) frames.
REQ-018 Latency: for acceptance at edge k, the first code bit SHALL appear on x in the cycle after edge k; one bit per cycle for CODE_W cycles, x_valid=1 throughout.
REQ-019 After the last bit of a frame, SEND SHALL go to GAP if GAP_BITS>0, else directly to the next frame's SEND, or to IDLE if this was the last frame.
REQ-020 GAP SHALL hold x=1, x_valid=0 for exactly GAP_BITS cycles, then reload the shift register from the latched code and return to SEND, or go to IDLE after the last frame.
REQ-021 Each frame SHALL therefore occupy CODE_W+GAP_BITS cycles; total transfer N*(CODE_W+GAP_BITS) cycles.
REQ-022 done SHALL be high for exactly the first IDLE cycle after normal completion, concurrent with ready=1.
REQ-023 start asserted while ready=0 SHALL be ignored and not queued.
REQ-024 A start accepted in the done cycle SHALL begin a new transfer with no extra idle cycle (back-to-back).
REQ-025 abort=1 at an edge in SEND or GAP SHALL return to IDLE at that edge: x=1, x_valid=0, no done pulse; abort in IDLE SHALL have no effect and SHALL take priority over simultaneous start.
REQ-026 Bit and gap counters SHALL not wrap; internal counter widths SHALL be sized by $clog2 of CODE_W and GAP_BITS.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, x=1, x_valid=0, ready=1, done=0, state=0, and clear shift register and counters, including mid-frame.
REQ-028 After rst deasserts, the first start SHALL be acceptable at the next clk edge.

Structure
REQ-029 State encoding constants (IDLE/SEND/GAP) SHALL live in the shared package code_pkg, also used by the code detector.
REQ-030 The shift-register-plus-bit-counter SHALL be one sub-module, code_shifter; the FSM stays in code_sender.

Verification
REQ-031 code_in=4'b0011, rep_in=1, start pulse at edge 0 -> x=0,0,1,1 in cycles 1-4 (x_valid=1), x=1 in cycles 5-6, done=1 in cycle 7; x fed into the 0011 detector gives y=1 once.
REQ-032 code_in=4'b1010, rep_in=3 -> pattern 1,0,1,0,1,1 repeated 3 times, 18 cycles, single done pulse.
REQ-033 rep_in=0 -> identical to rep_in=1; start held high during busy -> exactly one transfer until done, then a back-to-back second transfer begins the cycle after the done edge.
REQ-034 abort at cycle 3 of a frame -> x=1, x_valid=0, ready=1 next cycle, done never asserted.
REQ-035 rst asserted asynchronously mid-SEND -> outputs reach reset values before the next clk edge; a following start transmits cleanly.
REQ-036 GAP_BITS=0, rep_in=2, code 0011 -> x=0,0,1,1,0,0,1,1 contiguous, x_valid=1 for 8 cycles.
